// File: rtl/load_store_unit_if.sv
// Pipeline-side and memory-side signal bundle for the load/store unit.
// The master modport is the LSU's view; slave is the environment's view.
interface load_store_unit_if;
    logic        valid_i;
    logic        we_i;
    logic [1:0]  width_src_i;
    logic        unsigned_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        done_o;
    logic        misaligned_o;
    logic        stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    modport master (
        input  valid_i, we_i, width_src_i, unsigned_i, addr_i, wdata_i,
        input  mem_ack_i, mem_rdata_i,
        output rdata_o, done_o, misaligned_o, stall_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
    );

    modport slave (
        output valid_i, we_i, width_src_i, unsigned_i, addr_i, wdata_i,
        output mem_ack_i, mem_rdata_i,
        input  rdata_o, done_o, misaligned_o, stall_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
    );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: aligns stores onto byte lanes,
// extracts and extends loads, and faults misaligned accesses without a bus cycle.
module load_store_unit (
    input  logic              clk_i,
    input  logic              reset_i,
    load_store_unit_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    localparam logic [1:0] W_WORD = 2'b00;
    localparam logic [1:0] W_HALF = 2'b10;
    localparam logic [1:0] W_BYTE = 2'b01;

    state_t      r_state;
    state_t      w_next;
    logic        r_we;
    logic        r_unsigned;
    logic        r_mis;
    logic [1:0]  r_width;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;

    logic        w_mis;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_load;
    logic [15:0] w_half;
    logic [7:0]  w_byte;
    logic        w_accept;

    // Alignment check works on the live request, before anything is captured.
    always_comb begin
        w_mis = 1'b0;
        unique case (bus.width_src_i)
            W_WORD:  w_mis = |bus.addr_i[1:0];
            W_HALF:  w_mis = bus.addr_i[0];
            W_BYTE:  w_mis = 1'b0;
            default: w_mis = 1'b1;
        endcase
    end

    assign w_accept = (r_state == IDLE) && bus.valid_i;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = r_wdata;
        unique case (r_width)
            W_HALF: begin
                w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{r_wdata[15:0]}};
            end
            W_BYTE: begin
                w_be    = 4'b0001 << r_addr[1:0];
                w_wdata = {4{r_wdata[7:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = r_wdata;
            end
        endcase
    end

    always_comb begin
        w_half = r_addr[1] ? bus.mem_rdata_i[31:16] : bus.mem_rdata_i[15:0];
        w_byte = bus.mem_rdata_i[7:0];
        unique case (r_addr[1:0])
            2'd1:    w_byte = bus.mem_rdata_i[15:8];
            2'd2:    w_byte = bus.mem_rdata_i[23:16];
            2'd3:    w_byte = bus.mem_rdata_i[31:24];
            default: w_byte = bus.mem_rdata_i[7:0];
        endcase
        unique case (r_width)
            W_HALF:  w_load = {{16{~r_unsigned & w_half[15]}}, w_half};
            W_BYTE:  w_load = {{24{~r_unsigned & w_byte[7]}}, w_byte};
            default: w_load = bus.mem_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next           = r_state;
        bus.stall_o      = 1'b0;
        bus.done_o       = 1'b0;
        bus.misaligned_o = 1'b0;
        bus.rdata_o      = 32'd0;
        bus.mem_req_o    = 1'b0;
        bus.mem_we_o     = 1'b0;
        bus.mem_addr_o   = 32'd0;
        bus.mem_be_o     = 4'd0;
        bus.mem_wdata_o  = 32'd0;
        unique case (r_state)
            IDLE: begin
                if (bus.valid_i) begin
                    bus.stall_o = 1'b1;
                    w_next      = w_mis ? RESP : REQ;
                end
            end
            REQ: begin
                bus.stall_o     = 1'b1;
                bus.mem_req_o   = 1'b1;
                bus.mem_we_o    = r_we;
                bus.mem_addr_o  = {r_addr[31:2], 2'b00};
                bus.mem_be_o    = r_we ? w_be : 4'b1111;
                bus.mem_wdata_o = r_we ? w_wdata : 32'd0;
                if (bus.mem_ack_i) w_next = RESP;
            end
            RESP: begin
                bus.done_o       = 1'b1;
                bus.misaligned_o = r_mis;
                bus.rdata_o      = r_rdata;
                w_next           = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_we       <= 1'b0;
            r_unsigned <= 1'b0;
            r_mis      <= 1'b0;
            r_width    <= 2'b00;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_rdata    <= 32'd0;
        end else if (w_accept) begin
            r_mis   <= w_mis;
            r_rdata <= 32'd0;
            if (!w_mis) begin
                r_we       <= bus.we_i;
                r_unsigned <= bus.unsigned_i;
                r_width    <= bus.width_src_i;
                r_addr     <= bus.addr_i;
                r_wdata    <= bus.wdata_i;
            end
        end else if (r_state == REQ && bus.mem_ack_i) begin
            r_rdata <= r_we ? 32'd0 : w_load;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit against a byte-addressed
// reference memory model; a memory responder supplies wait states.
module tb_load_store_unit;
    typedef struct {
        logic [31:0] rdata;
        logic        mis;
    } resp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mreq_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    load_store_unit_if bus ();

    load_store_unit dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    resp_t       exp_q[$];
    mreq_t       req_q[$];
    logic [7:0]  ref_mem[256];
    logic [31:0] mem_w[64];
    int          n_chk = 0;
    int          n_fail = 0;
    int          wait_cycles = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int size_of(input logic [1:0] w);
        case (w)
            2'b00:   return 4;
            2'b10:   return 2;
            2'b01:   return 1;
            default: return 0;
        endcase
    endfunction

    // Memory responder: acks after wait_cycles and checks each request cycle.
    mreq_t cur;
    logic  active = 1'b0;
    int    cnt = 0;
    always @(negedge clk) begin
        if (bus.mem_req_o) begin
            if (!active) begin
                active = 1'b1;
                cnt = 0;
                if (req_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_mem_req: got addr %h, expected none",
                             bus.mem_addr_o);
                    cur.we = bus.mem_we_o;
                    cur.addr = bus.mem_addr_o;
                    cur.be = bus.mem_be_o;
                    cur.wdata = bus.mem_wdata_o;
                end else begin
                    cur = req_q.pop_front();
                end
            end
            chk("mem_we", 32'(bus.mem_we_o), 32'(cur.we));
            chk("mem_addr", bus.mem_addr_o, cur.addr);
            chk("mem_be", 32'(bus.mem_be_o), 32'(cur.be));
            chk("mem_wdata", bus.mem_wdata_o, cur.wdata);
            if (cnt == wait_cycles) begin
                bus.mem_ack_i = 1'b1;
                bus.mem_rdata_i = mem_w[bus.mem_addr_o[7:2]];
                if (bus.mem_we_o)
                    for (int i = 0; i < 4; i++)
                        if (bus.mem_be_o[i])
                            mem_w[bus.mem_addr_o[7:2]][8*i +: 8] = bus.mem_wdata_o[8*i +: 8];
            end else begin
                bus.mem_ack_i = 1'b0;
                bus.mem_rdata_i = $urandom;
            end
            cnt++;
        end else begin
            active = 1'b0;
            cnt = 0;
            bus.mem_ack_i = 1'($urandom_range(0, 1));
            bus.mem_rdata_i = $urandom;
        end
    end

    // Response monitor: every done_o pops one expected response.
    always @(negedge clk) begin
        resp_t e;
        if (bus.done_o) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: got rdata %h, expected no completion",
                         bus.rdata_o);
            end else begin
                e = exp_q.pop_front();
                chk("rdata", bus.rdata_o, e.rdata);
                chk("misaligned", 32'(bus.misaligned_o), 32'(e.mis));
            end
        end else if (bus.misaligned_o) begin
            n_chk++;
            n_fail++;
            $display("FAIL lone_misaligned: got 1, expected 0 without done");
        end
    end

    task automatic garble();
        bus.valid_i = 1'($urandom_range(0, 1));
        bus.we_i = 1'($urandom_range(0, 1));
        bus.width_src_i = 2'($urandom_range(0, 3));
        bus.unsigned_i = 1'($urandom_range(0, 1));
        bus.addr_i = $urandom;
        bus.wdata_i = $urandom;
    endtask

    task automatic access(input logic we, input logic [1:0] w, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int waits);
        int s;
        logic mis;
        mreq_t r;
        resp_t e;
        logic [31:0] v;
        int lat;
        int exp_lat;
        s = size_of(w);
        mis = (s == 0) ? 1'b1 : (a % s != 0);
        e.mis = mis;
        e.rdata = 32'd0;
        if (!mis) begin
            r.we = we;
            r.addr = a & ~32'h3;
            r.be = we ? 4'(((32'd1 << s) - 1) << a[1:0]) : 4'hF;
            r.wdata = 32'd0;
            if (we) begin
                for (int i = 0; i < 4; i++)
                    r.wdata[8*i +: 8] = wd[8*(i % s) +: 8];
                for (int k = 0; k < s; k++)
                    ref_mem[int'((a + 32'(k)) & 32'hFF)] = wd[8*k +: 8];
            end else begin
                v = 32'd0;
                for (int k = 0; k < s; k++)
                    v |= 32'(ref_mem[int'((a + 32'(k)) & 32'hFF)]) << (8*k);
                if (!uns && s < 4 && v[8*s-1])
                    v |= ~((32'd1 << (8*s)) - 1);
                e.rdata = v;
            end
            req_q.push_back(r);
        end
        exp_q.push_back(e);
        wait_cycles = waits;
        exp_lat = mis ? 1 : 2 + waits;

        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.we_i = we;
        bus.width_src_i = w;
        bus.unsigned_i = uns;
        bus.addr_i = a;
        bus.wdata_i = wd;
        #1 chk("stall_idle", 32'(bus.stall_o), 32'd1);
        @(posedge clk);
        #1 bus.valid_i = 1'b0;
        lat = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (bus.done_o) break;
            chk("stall_busy", 32'(bus.stall_o), 32'd1);
            if (lat >= 40) begin
                n_chk++;
                n_fail++;
                $display("FAIL timeout: got no done after %0d cycles, expected %0d",
                         lat, exp_lat);
                break;
            end
            garble();
        end
        bus.valid_i = 1'b0;
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("stall_resp", 32'(bus.stall_o), 32'd0);
        chk("req_in_resp", 32'(bus.mem_req_o), 32'd0);
        @(negedge clk);
        chk("done_once", 32'(bus.done_o), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_done"}, 32'(bus.done_o), 32'd0);
        chk({tag, "_mis"}, 32'(bus.misaligned_o), 32'd0);
        chk({tag, "_rdata"}, bus.rdata_o, 32'd0);
        chk({tag, "_req"}, 32'(bus.mem_req_o), 32'd0);
        chk({tag, "_we"}, 32'(bus.mem_we_o), 32'd0);
        chk({tag, "_addr"}, bus.mem_addr_o, 32'd0);
        chk({tag, "_be"}, 32'(bus.mem_be_o), 32'd0);
        chk({tag, "_wdata"}, bus.mem_wdata_o, 32'd0);
    endtask

    initial begin
        mreq_t r;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        for (int i = 0; i < 64; i++) mem_w[i] = 32'h0;
        rst = 1'b1;
        bus.valid_i = 1'b0;
        bus.we_i = 1'b0;
        bus.width_src_i = 2'b00;
        bus.unsigned_i = 1'b0;
        bus.addr_i = 32'd0;
        bus.wdata_i = 32'd0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        chk("reset_stall", 32'(bus.stall_o), 32'd0);
        rst = 1'b0;

        access(1'b1, 2'b00, 1'b0, 32'h10, 32'hDEADBEEF, 0);
        access(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 0);
        access(1'b1, 2'b00, 1'b0, 32'h20, 32'h80FF7F01, 0);
        access(1'b0, 2'b01, 1'b0, 32'h23, 32'h0, 0);
        access(1'b0, 2'b01, 1'b1, 32'h23, 32'h0, 0);
        access(1'b1, 2'b10, 1'b0, 32'h06, 32'h0000ABCD, 1);
        access(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 0);
        access(1'b0, 2'b00, 1'b0, 32'h02, 32'h0, 0);
        access(1'b1, 2'b11, 1'b0, 32'h08, 32'h12345678, 0);
        access(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 3);

        // Reset while a store is stalled in the bus cycle.
        r.we = 1'b1;
        r.addr = 32'h30;
        r.be = 4'hF;
        r.wdata = 32'h11223344;
        req_q.push_back(r);
        wait_cycles = 10;
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.we_i = 1'b1;
        bus.width_src_i = 2'b00;
        bus.addr_i = 32'h30;
        bus.wdata_i = 32'h11223344;
        @(posedge clk);
        #1 bus.valid_i = 1'b0;
        @(negedge clk);
        chk("abort_req_up", 32'(bus.mem_req_o), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1 chk_all_zero("abort");
        chk("abort_stall", 32'(bus.stall_o), 32'd0);
        req_q.delete();
        repeat (2) @(negedge clk) chk("abort_no_done", 32'(bus.done_o), 32'd0);
        access(1'b0, 2'b00, 1'b0, 32'h30, 32'h0, 0);

        // Reset wins over a same-cycle request.
        @(negedge clk);
        rst = 1'b1;
        bus.valid_i = 1'b1;
        bus.we_i = 1'b0;
        bus.width_src_i = 2'b00;
        bus.addr_i = 32'h10;
        @(negedge clk);
        rst = 1'b0;
        bus.valid_i = 1'b0;
        #1 chk_all_zero("rst_prio");
        @(negedge clk);
        chk("rst_prio_no_done", 32'(bus.done_o), 32'd0);

        for (int n = 0; n < 200; n++)
            access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)),
                   $urandom, $urandom_range(0, 3));

        repeat (3) @(negedge clk);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("req_q_drained", 32'(req_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
